gray_step_scheduler: RTL and testbench

Round-robin scheduler that shares one 3-bit Gray code counter among several requesters. Each requester asks for a number of count steps in a chosen direction. The scheduler grants one request at a time, drives the counter's step enable and direction for exactly that many cycles, and reports completion with the counter's resulting Gray value. It sits between requesting control logic and the Gray counter datapath.

---
 rtl/gray_step_scheduler.sv | 124 ++++++++++++
 tb/tb_gray_step_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_scheduler.sv
// rtl/gray_step_scheduler.sv - round-robin arbiter that lends a shared Gray counter's
// step enable to one requester at a time for a requested number of steps
module gray_step_scheduler #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int WIDTH  = 3,
  parameter int STEP_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_up,
  input  logic [N_REQ*STEP_W-1:0]   req_steps,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      hold,
  input  logic [WIDTH-1:0]          gray_in,
  output logic                      step_en,
  output logic                      step_up,
  output logic                      busy,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic [WIDTH-1:0]          done_gray
);

  typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic                dir_q, dir_d;
  logic [STEP_W-1:0]   remaining_q, remaining_d;
  logic                done_q, done_d;
  logic [ID_W-1:0]     done_id_q, done_id_d;
  logic [WIDTH-1:0]    done_gray_q, done_gray_d;

  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     grant_id;
  logic                grant_found;

  // Search starts at rr_ptr and wraps, so the last owner ends up lowest priority.
  always_comb begin
    int idx;
    grant       = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant[idx]  = 1'b1;
        grant_id    = ID_W'(idx);
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    dir_d       = dir_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    done_gray_d = done_gray_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          owner_d     = grant_id;
          dir_d       = req_up[grant_id];
          remaining_d = req_steps[grant_id*STEP_W +: STEP_W];
          state_d     = (remaining_d != '0) ? RUN : SETTLE;
        end
      end
      RUN: begin
        if (!hold) begin
          remaining_d = remaining_q - STEP_W'(1);
          if (remaining_q == STEP_W'(1)) state_d = SETTLE;
        end
      end
      SETTLE: begin
        // gray_in has absorbed the last step by now, so it is the final value.
        done_d      = 1'b1;
        done_id_d   = owner_q;
        done_gray_d = gray_in;
        rr_ptr_d    = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      dir_q       <= 1'b0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      done_gray_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      dir_q       <= dir_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      done_gray_q <= done_gray_d;
    end
  end

  // Decoded from state so a reset drops step_en and busy without waiting for an edge.
  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign step_en   = (state_q == RUN) & ~hold;
  assign step_up   = (state_q == RUN) & dir_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign done_gray = done_gray_q;

endmodule

// File: tb/tb_gray_step_scheduler.sv
// tb/tb_gray_step_scheduler.sv - directed vector bench with a behavioural 3-bit Gray counter
module tb_gray_step_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_up;
  logic [15:0] req_steps;
  logic [3:0]  req_ready;
  logic        hold;
  logic [2:0]  gray_in;
  logic        step_en, step_up, busy, done;
  logic [1:0]  done_id;
  logic [2:0]  done_gray;

  logic [2:0]  gray_lut [0:7] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  logic [2:0]  pos = 3'd0;
  logic        load_en = 1'b0;
  logic [2:0]  load_val = 3'd0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_en)      pos <= load_val;
    else if (step_en) pos <= step_up ? pos + 3'd1 : pos - 3'd1;
  end
  assign gray_in = gray_lut[pos];

  gray_step_scheduler #(.N_REQ(4), .ID_W(2), .WIDTH(3), .STEP_W(4)) dut (
    .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_up(req_up),
    .req_steps(req_steps), .req_ready(req_ready), .hold(hold), .gray_in(gray_in),
    .step_en(step_en), .step_up(step_up), .busy(busy), .done(done),
    .done_id(done_id), .done_gray(done_gray)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_counter(input int p);
    @(negedge clk);
    load_en  = 1'b1;
    load_val = p[2:0];
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one request and counts negedges from presentation until done is seen.
  task automatic run_req(input int id, input bit up, input int steps, input int hs, input int hl,
                         output int cyc, output int nst, output logic [2:0] g,
                         output int did, output bit ok);
    bit acc_now;
    @(negedge clk);
    req_valid[id]          = 1'b1;
    req_up[id]             = up;
    req_steps[id*4 +: 4]   = steps[3:0];
    cyc = 0; nst = 0; ok = 1'b0; g = 3'd0; did = 0;
    while (cyc < 60 && !ok) begin
      hold = (cyc >= hs) && (cyc < hs + hl);
      #1;
      check("ready_onehot", {31'd0, $countones(req_ready) <= 1}, 32'd1);
      if (step_en) begin
        nst++;
        check("step_up", {31'd0, step_up}, {31'd0, up});
      end
      acc_now = req_ready[id] & req_valid[id];
      @(negedge clk);
      cyc++;
      if (acc_now) req_valid[id] = 1'b0;
      if (done) begin
        ok  = 1'b1;
        g   = done_gray;
        did = int'(done_id);
      end
    end
    hold = 1'b0;
    req_valid[id] = 1'b0;
  endtask

  typedef struct {
    int         id;
    bit         up;
    int         steps;
    bit         do_load;
    int         start;
    int         hs;
    int         hl;
    logic [2:0] exp_gray;
    int         exp_cyc;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int cyc, nst, did;
    bit ok;
    logic [2:0] g;
    int ids [3];
    logic [2:0] grays [3];
    int ndone;
    int done_seen;
    logic [3:0] clr;

    vecs[0] = '{0, 1'b1, 5,  1'b1, 0, 99, 0, 3'b111, 7};
    vecs[1] = '{2, 1'b0, 1,  1'b1, 0, 99, 0, 3'b100, 3};
    vecs[2] = '{2, 1'b1, 1,  1'b0, 0, 99, 0, 3'b000, 3};
    vecs[3] = '{3, 1'b1, 4,  1'b1, 0, 2,  3, 3'b110, 9};
    vecs[4] = '{1, 1'b1, 0,  1'b1, 4, 99, 0, 3'b110, 2};
    vecs[5] = '{1, 1'b0, 3,  1'b1, 1, 99, 0, 3'b101, 5};
    vecs[6] = '{3, 1'b1, 15, 1'b1, 0, 99, 0, 3'b100, 17};
    vecs[7] = '{0, 1'b1, 2,  1'b1, 0, 0,  1, 3'b011, 4};

    rst_n = 1'b0; req_valid = '0; req_up = '0; req_steps = '0; hold = 1'b0;
    #1;
    check("rst_step_en", {31'd0, step_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    do_reset();
    #1;
    check("rst_step_up", {31'd0, step_up}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_done_id", {30'd0, done_id}, 32'd0);
    check("rst_done_gray", {29'd0, done_gray}, 32'd0);
    check("rst_ready", {28'd0, req_ready}, 32'd0);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].do_load) load_counter(vecs[v].start);
      run_req(vecs[v].id, vecs[v].up, vecs[v].steps, vecs[v].hs, vecs[v].hl, cyc, nst, g, did, ok);
      check($sformatf("v%0d_done_seen", v), {31'd0, ok}, 32'd1);
      check($sformatf("v%0d_gray", v), {29'd0, g}, {29'd0, vecs[v].exp_gray});
      check($sformatf("v%0d_id", v), did, vecs[v].id);
      check($sformatf("v%0d_latency", v), cyc, vecs[v].exp_cyc);
      check($sformatf("v%0d_steps", v), nst, vecs[v].steps);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", v), {31'd0, done}, 32'd0);
      check($sformatf("v%0d_gray_held", v), {29'd0, done_gray}, {29'd0, vecs[v].exp_gray});
    end

    // Three simultaneous 1-step requests from a freshly reset pointer.
    do_reset();
    load_counter(0);
    @(negedge clk);
    req_valid = 4'b1011; req_up = 4'b1111; req_steps = 16'h1111;
    ndone = 0;
    for (int c = 0; c < 40 && ndone < 3; c++) begin
      #1;
      check("multi_onehot", {31'd0, $countones(req_ready) <= 1}, 32'd1);
      clr = req_ready & req_valid;
      @(negedge clk);
      req_valid = req_valid & ~clr;
      if (done) begin
        ids[ndone]   = int'(done_id);
        grays[ndone] = done_gray;
        ndone++;
      end
    end
    check("multi_count", ndone, 3);
    check("multi_id0", ids[0], 0);
    check("multi_id1", ids[1], 1);
    check("multi_id2", ids[2], 3);
    check("multi_gray0", {29'd0, grays[0]}, 32'h1);
    check("multi_gray1", {29'd0, grays[1]}, 32'h3);
    check("multi_gray2", {29'd0, grays[2]}, 32'h2);
    req_valid = '0;

    // Move rr_ptr to 2, then reset in the middle of a 6-step run.
    run_req(1, 1'b1, 1, 99, 0, cyc, nst, g, did, ok);
    check("pre_done_seen", {31'd0, ok}, 32'd1);
    @(negedge clk);
    req_valid[2] = 1'b1; req_up[2] = 1'b1; req_steps[11:8] = 4'd6;
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    check("mid_run_step_en", {31'd0, step_en}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_step_en", {31'd0, step_en}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("no_done_after_reset", done_seen, 0);
    req_valid = 4'b1010;
    #1;
    check("post_reset_grant", {28'd0, req_ready}, 32'h2);
    @(negedge clk);
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
